// File: rtl/eq_pkg.sv
// Shared equalizer constants and the I2C register-file FSM state encoding.
// Imported by the gain register block and the equalizer core so band count and gain width agree.
package eq_pkg;

  localparam int              NUM_BANDS_DEF = 10;
  localparam int              GAIN_W        = 8;
  localparam logic [GAIN_W-1:0] GAIN_UNITY  = 8'd128;
  localparam logic [7:0]      REG_BASE      = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_REG,
    ST_ACK_REG,
    ST_DATA,
    ST_ACK_DATA,
    ST_IGNORE,
    ST_READ,
    ST_READ_ACK
  } i2c_state_e;

endpackage

// File: rtl/eq_i2c_gain_regs_if.sv
// I2C pad-side signals of the gain register slave: raw SCL/SDA in, open-drain SDA pull-down out.
interface eq_i2c_gain_regs_if;

  logic i2c_scl;
  logic i2c_sda_i;
  logic i2c_sda_oe;

  modport master (output i2c_scl, output i2c_sda_i, input  i2c_sda_oe);
  modport slave  (input  i2c_scl, input  i2c_sda_i, output i2c_sda_oe);

endinterface

// File: rtl/eq_i2c_line_sync.sv
// Synchronizes raw SCL/SDA into clk and derives one-clk scl_rise/scl_fall/start/stop pulses.
module eq_i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;

  // Preset to 1 so leaving reset on an idle bus never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign sda_o      = sda_sync_q[1];
  assign scl_rise_o =  scl_sync_q[1] & ~scl_hist_q;
  assign scl_fall_o = ~scl_sync_q[1] &  scl_hist_q;
  assign start_o    =  scl_sync_q[1] & scl_hist_q &  sda_hist_q & ~sda_sync_q[1];
  assign stop_o     =  scl_sync_q[1] & scl_hist_q & ~sda_hist_q &  sda_sync_q[1];

endmodule

// File: rtl/eq_i2c_gain_regs.sv
// I2C write slave holding one gain code per equalizer band (registers 0x01..NUM_BANDS).
// Optional read-back of the gain registers is enabled by defining EQ_I2C_READ_EN.
module eq_i2c_gain_regs
  import eq_pkg::*;
#(
  parameter logic [6:0]        SLAVE_ADDR = 7'h2A,
  parameter int                NUM_BANDS  = NUM_BANDS_DEF,
  parameter logic [GAIN_W-1:0] GAIN_RESET = GAIN_UNITY
) (
  input  logic                        clk,
  input  logic                        rst,
  eq_i2c_gain_regs_if.slave           i2c,
  output logic [NUM_BANDS*GAIN_W-1:0] gain_bus,
  output logic                        gain_wr,
  output logic [3:0]                  gain_wr_idx,
  output logic                        busy
);

  localparam logic [7:0] LAST_REG = 8'(NUM_BANDS);

  logic sda, scl_rise, scl_fall, bus_start, bus_stop;

  eq_i2c_line_sync u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (i2c.i2c_scl),
    .sda_i      (i2c.i2c_sda_i),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (bus_start),
    .stop_o     (bus_stop)
  );

  i2c_state_e                  state_q;
  logic [7:0]                  ptr_q;
  logic [6:0]                  shift_q;
  logic [2:0]                  bit_cnt_q;
  logic                        ack_q, ack_phase_q, oe_q, busy_q;
  logic [NUM_BANDS*GAIN_W-1:0] gain_q;
  logic                        gain_wr_q;
  logic [3:0]                  gain_wr_idx_q;

  logic [7:0] rx_byte_d;
  logic [7:0] ptr_d;
  logic [3:0] wr_idx_d;
  logic       in_range_d, last_bit_d, addr_ok_d;

  assign rx_byte_d  = {shift_q, sda};
  assign ptr_d      = (ptr_q == 8'hFF) ? ptr_q : ptr_q + 8'd1;
  assign wr_idx_d   = 4'(ptr_q - REG_BASE);
  assign in_range_d = (ptr_q >= REG_BASE) && (ptr_q <= LAST_REG);
  assign last_bit_d = (bit_cnt_q == 3'd7);

`ifdef EQ_I2C_READ_EN
  logic       rd_mode_q;
  logic [7:0] rd_byte_d;
  assign rd_byte_d = in_range_d ? gain_q[int'(wr_idx_d)*GAIN_W +: GAIN_W] : 8'hFF;
  assign addr_ok_d = (rx_byte_d[7:1] == SLAVE_ADDR);
`else
  assign addr_ok_d = (rx_byte_d[7:1] == SLAVE_ADDR) && !rx_byte_d[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ack_q         <= 1'b0;
      ack_phase_q   <= 1'b0;
      oe_q          <= 1'b0;
      busy_q        <= 1'b0;
      // NOTE: the gain file is flops, not RAM, so it can and must be reset to unity.
      gain_q        <= {NUM_BANDS{GAIN_RESET}};
      gain_wr_q     <= 1'b0;
      gain_wr_idx_q <= '0;
`ifdef EQ_I2C_READ_EN
      rd_mode_q     <= 1'b0;
`endif
    end else begin
      gain_wr_q <= 1'b0;
      if (bus_stop) begin
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (bus_start) begin
        state_q   <= ST_ADDR;
        oe_q      <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_ADDR: if (scl_rise) begin
            shift_q   <= rx_byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit_d) begin
              ack_q       <= 1'b1;
              ack_phase_q <= 1'b0;
              busy_q      <= addr_ok_d;
              state_q     <= addr_ok_d ? ST_ACK_ADDR : ST_IGNORE;
`ifdef EQ_I2C_READ_EN
              rd_mode_q   <= rx_byte_d[0];
`endif
            end
          end
          ST_REG: if (scl_rise) begin
            shift_q   <= rx_byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit_d) begin
              ptr_q       <= rx_byte_d;
              ack_q       <= 1'b1;
              ack_phase_q <= 1'b0;
              state_q     <= ST_ACK_REG;
            end
          end
          ST_DATA: if (scl_rise) begin
            shift_q   <= rx_byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit_d) begin
              ack_q       <= in_range_d;
              ack_phase_q <= 1'b0;
              ptr_q       <= ptr_d;
              state_q     <= ST_ACK_DATA;
              if (in_range_d) begin
                gain_q[int'(wr_idx_d)*GAIN_W +: GAIN_W] <= rx_byte_d;
                gain_wr_q     <= 1'b1;
                gain_wr_idx_q <= wr_idx_d;
              end
            end
          end
          // First scl_fall drives ACK/NACK for the ninth clock, the second releases it.
          ST_ACK_ADDR, ST_ACK_REG, ST_ACK_DATA: if (scl_fall) begin
            if (!ack_phase_q) begin
              oe_q        <= ack_q;
              ack_phase_q <= 1'b1;
            end else begin
              oe_q      <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= (state_q == ST_ACK_ADDR) ? ST_REG : ST_DATA;
`ifdef EQ_I2C_READ_EN
              if (state_q == ST_ACK_ADDR && rd_mode_q) begin
                shift_q <= rd_byte_d[6:0];
                oe_q    <= ~rd_byte_d[7];
                state_q <= ST_READ;
              end
`endif
            end
          end
`ifdef EQ_I2C_READ_EN
          ST_READ: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit_d) begin
                ack_phase_q <= 1'b0;
                ptr_q       <= ptr_d;
                state_q     <= ST_READ_ACK;
              end
            end else if (scl_fall) begin
              shift_q <= {shift_q[5:0], 1'b0};
              oe_q    <= ~shift_q[6];
            end
          end
          ST_READ_ACK: begin
            if (scl_rise && ack_phase_q) begin
              ack_q <= ~sda;
            end else if (scl_fall) begin
              if (!ack_phase_q) begin
                oe_q        <= 1'b0;
                ack_phase_q <= 1'b1;
              end else if (ack_q) begin
                shift_q   <= rd_byte_d[6:0];
                oe_q      <= ~rd_byte_d[7];
                bit_cnt_q <= '0;
                state_q   <= ST_READ;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
`endif
          ST_IGNORE: oe_q <= 1'b0;
          ST_IDLE:   oe_q <= 1'b0;
          default:   state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign i2c.i2c_sda_oe = oe_q;
  assign gain_bus       = gain_q;
  assign gain_wr        = gain_wr_q;
  assign gain_wr_idx    = gain_wr_idx_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_eq_i2c_gain_regs.sv
// Directed bench for eq_i2c_gain_regs: a bit-banged I2C master plus a gain_wr scoreboard monitor.
module tb_eq_i2c_gain_regs;

  localparam int NB   = 10;
  localparam int HALF = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic [NB*8-1:0] gain_bus;
  logic          gain_wr;
  logic [3:0]    gain_wr_idx;
  logic          busy;

  eq_i2c_gain_regs_if bus ();
  assign bus.i2c_scl   = m_scl;
  assign bus.i2c_sda_i = m_sda & ~bus.i2c_sda_oe;

  eq_i2c_gain_regs dut (
    .clk         (clk),
    .rst         (rst),
    .i2c         (bus),
    .gain_bus    (gain_bus),
    .gain_wr     (gain_wr),
    .gain_wr_idx (gain_wr_idx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] val;
  } wr_t;

  wr_t             exp_q[$];
  wr_t             mon_e;
  logic [NB*8-1:0] model = {NB{8'h80}};
  int              n_vec  = 0;
  int              n_miss = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int band, input logic [7:0] v);
    exp_q.push_back('{idx: 4'(band), val: v});
    model[band*8 +: 8] = v;
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1;
      tick(HALF);
      m_scl = 1'b1;
      tick(2*HALF);
    end
    m_sda = 1'b0;
    tick(2*HALF);
    m_scl = 1'b0;
    tick(HALF);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    tick(HALF);
    m_scl = 1'b1;
    tick(2*HALF);
    m_sda = 1'b1;
    tick(2*HALF);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    tick(HALF);
    m_scl = 1'b1;
    tick(2*HALF);
    m_scl = 1'b0;
    tick(HALF);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    m_sda = 1'b1;
    tick(HALF);
    m_scl = 1'b1;
    tick(HALF);
    ack = (bus.i2c_sda_i == 1'b0);
    tick(HALF);
    m_scl = 1'b0;
    tick(HALF);
  endtask

  task automatic byte_chk(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    send_byte(d, a);
    check(name, 128'(a), 128'(exp_ack));
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1;
      tick(HALF);
      m_scl = 1'b1;
      tick(HALF);
      d[i] = bus.i2c_sda_i;
      tick(HALF);
      m_scl = 1'b0;
      tick(HALF);
    end
    send_bit(master_ack ? 1'b0 : 1'b1);
  endtask

  // Scoreboard monitor: every gain_wr pulse must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && gain_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL gain_wr_unexpected: got pulse idx=%0d, expected no pulse", gain_wr_idx);
        end else begin
          mon_e = exp_q.pop_front();
          check("gain_wr_idx", 128'(gain_wr_idx), 128'(mon_e.idx));
          check("gain_wr_data", 128'(gain_bus[int'(mon_e.idx)*8 +: 8]), 128'(mon_e.val));
        end
      end
    end
  end

  initial begin
    logic [7:0] rd;
    tick(5);
    rst = 1'b0;
    tick(40);
    check("reset_gains", 128'(gain_bus), 128'(model));
    check("reset_oe", 128'(bus.i2c_sda_oe), 128'(1'b0));
    check("reset_busy", 128'(busy), 128'(1'b0));
    check("reset_idx", 128'(gain_wr_idx), 128'(4'd0));

    // Single write: reg 0x03 <- 0x0F
    i2c_start();
    byte_chk("w1_addr_ack", 8'h54, 1'b1);
    check("w1_busy", 128'(busy), 128'(1'b1));
    byte_chk("w1_reg_ack", 8'h03, 1'b1);
    expect_wr(2, 8'h0F);
    byte_chk("w1_data_ack", 8'h0F, 1'b1);
    i2c_stop();
    check("w1_gains", 128'(gain_bus), 128'(model));
    check("w1_busy_after_stop", 128'(busy), 128'(1'b0));

    // Burst from reg 0x09: third byte runs past the last band
    i2c_start();
    byte_chk("burst_addr_ack", 8'h54, 1'b1);
    byte_chk("burst_reg_ack", 8'h09, 1'b1);
    expect_wr(8, 8'h2D);
    byte_chk("burst_d0_ack", 8'h2D, 1'b1);
    expect_wr(9, 8'h32);
    byte_chk("burst_d1_ack", 8'h32, 1'b1);
    byte_chk("burst_d2_nack", 8'h77, 1'b0);
    i2c_stop();
    check("burst_gains", 128'(gain_bus), 128'(model));

    // Foreign address 0x55: everything NACKed
    i2c_start();
    byte_chk("foreign_addr_nack", 8'hAA, 1'b0);
    check("foreign_busy", 128'(busy), 128'(1'b0));
    byte_chk("foreign_reg_nack", 8'h04, 1'b0);
    byte_chk("foreign_data_nack", 8'h99, 1'b0);
    i2c_stop();
    check("foreign_gains", 128'(gain_bus), 128'(model));

    // Register 0x00 is out of range
    i2c_start();
    byte_chk("reg0_addr_ack", 8'h54, 1'b1);
    byte_chk("reg0_reg_ack", 8'h00, 1'b1);
    byte_chk("reg0_data_nack", 8'h11, 1'b0);
    i2c_stop();
    check("reg0_gains", 128'(gain_bus), 128'(model));

    // Repeated start after 4 data bits aborts the partial byte
    i2c_start();
    byte_chk("rs_addr_ack", 8'h54, 1'b1);
    byte_chk("rs_reg_ack", 8'h01, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_start();
    byte_chk("rs2_addr_ack", 8'h54, 1'b1);
    byte_chk("rs2_reg_ack", 8'h01, 1'b1);
    expect_wr(0, 8'h05);
    byte_chk("rs2_data_ack", 8'h05, 1'b1);
    i2c_stop();
    check("rs_gains", 128'(gain_bus), 128'(model));

    // Reset mid-DATA after writing reg 0x02
    i2c_start();
    byte_chk("mr_addr_ack", 8'h54, 1'b1);
    byte_chk("mr_reg_ack", 8'h02, 1'b1);
    expect_wr(1, 8'h44);
    byte_chk("mr_data_ack", 8'h44, 1'b1);
    check("mr_gains_before", 128'(gain_bus), 128'(model));
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(6);
    rst = 1'b0;
    model = {NB{8'h80}};
    tick(20);
    check("mr_gains_reset", 128'(gain_bus), 128'(model));
    check("mr_busy", 128'(busy), 128'(1'b0));
    check("mr_oe", 128'(bus.i2c_sda_oe), 128'(1'b0));

    i2c_start();
    byte_chk("post_addr_ack", 8'h54, 1'b1);
    byte_chk("post_reg_ack", 8'h0A, 1'b1);
    expect_wr(9, 8'hC8);
    byte_chk("post_data_ack", 8'hC8, 1'b1);
    i2c_stop();
    check("post_gains", 128'(gain_bus), 128'(model));

`ifdef EQ_I2C_READ_EN
    i2c_start();
    byte_chk("rd_waddr_ack", 8'h54, 1'b1);
    byte_chk("rd_reg_ack", 8'h01, 1'b1);
    i2c_start();
    byte_chk("rd_raddr_ack", 8'h55, 1'b1);
    recv_byte(1'b0, rd);
    i2c_stop();
    check("rd_reg1", 128'(rd), 128'(8'h80));
`else
    i2c_start();
    byte_chk("rd_disabled_nack", 8'h55, 1'b0);
    i2c_stop();
    rd = gain_bus[7:0];
    check("rd_disabled_gains", 128'(gain_bus), 128'(model));
`endif

    tick(20);
    check("sb_drain", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
